sd_dat_serdes: RTL and testbench

SD_DAT_SERDES -- requirements
Module: sd_dat_serdes

---
 rtl/sd_dat_serdes.sv | 231 +++++++++++++++++++++++
 tb/tb_sd_dat_serdes.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_dat_serdes.sv
// sd_dat_serdes
//   SD-card DAT0 line serializer/deserializer with CRC16-CCITT.
//   Transmit: start bit, 32 data bits MSB first, 16 CRC bits, end bit.
//   Receive:  either a data block (word + CRC16 + end bit) or a CRC-status
//             token (3 status bits + end bit) followed by busy (DAT0 low).
//
// Ports
//   sd_clock              sole clock, rising edge
//   reset                 synchronous active-high reset
//   reset_wrapper         synchronous soft reset / abort from the DAT controller
//   load_send             transmit request, dataPARALLEL valid
//   enable_pts_wrapper    parallel-to-serial (transmit) enable
//   enable_stp_wrapper    serial-to-parallel (receive) enable
//   waiting_response      receive mode: 1 = status token + busy, 0 = data block
//   dataPARALLEL[31:0]    word to transmit
//   dat_in                DAT0 from pad
//   dat_out               DAT0 to pad (idles high)
//   dat_oe                pad drive enable
//   transmission_complete one-cycle pulse after the end bit is sent
//   reception_complete    one-cycle pulse when a receive finishes
//   dataRead[31:0]        last received data word
//   crc_error             error flag of the last receive
//   crc_status[2:0]       status bits of the last token
module sd_dat_serdes #(
    parameter logic [15:0] CRC_INIT = 16'h0000
) (
    input  logic        sd_clock,
    input  logic        reset,
    input  logic        reset_wrapper,
    input  logic        load_send,
    input  logic        enable_pts_wrapper,
    input  logic        enable_stp_wrapper,
    input  logic        waiting_response,
    input  logic [31:0] dataPARALLEL,
    input  logic        dat_in,
    output logic        dat_out,
    output logic        dat_oe,
    output logic        transmission_complete,
    output logic        reception_complete,
    output logic [31:0] dataRead,
    output logic        crc_error,
    output logic [2:0]  crc_status
);

    typedef enum logic [3:0] {
        IDLE, TX_START, TX_DATA, TX_CRC, TX_END, TX_DONE,
        RX_WAIT, RX_DATA, RX_CRC, RX_END, RX_DONE,
        TOK_STAT, TOK_END, BUSY
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [15:0] r_crc;
    logic [31:0] r_shift;      // transmit word / receive shadow
    logic [15:0] r_crc_rx;     // CRC field received from the card
    logic        r_mode;       // latched waiting_response
    logic        r_end_ok;     // token end bit
    logic        r_dat_out;
    logic        r_dat_oe;
    logic        r_tx_done;
    logic        r_rx_done;
    logic [31:0] r_data_read;
    logic        r_crc_error;
    logic [2:0]  r_crc_status;

    logic [15:0] w_crc_tx_next;
    logic [15:0] w_crc_rx_next;

    // One serial step of x^16 + x^12 + x^5 + 1.
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb       = crc[15] ^ b;
        crc_step = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign w_crc_tx_next = crc_step(r_crc, r_shift[31]);
    assign w_crc_rx_next = crc_step(r_crc, dat_in);

    always_ff @(posedge sd_clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_crc        <= '0;
            r_shift      <= '0;
            r_crc_rx     <= '0;
            r_mode       <= 1'b0;
            r_end_ok     <= 1'b0;
            r_dat_out    <= 1'b1;
            r_dat_oe     <= 1'b0;
            r_tx_done    <= 1'b0;
            r_rx_done    <= 1'b0;
            r_data_read  <= '0;
            r_crc_error  <= 1'b0;
            r_crc_status <= '0;
        end else if (reset_wrapper) begin
            // Abort: results of the previous receive stay visible.
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_crc     <= '0;
            r_dat_out <= 1'b1;
            r_dat_oe  <= 1'b0;
            r_tx_done <= 1'b0;
            r_rx_done <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            r_rx_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_dat_out <= 1'b1;
                    r_dat_oe  <= 1'b0;
                    r_cnt     <= '0;
                    if (enable_pts_wrapper && load_send) begin
                        r_shift   <= dataPARALLEL;
                        r_crc     <= CRC_INIT;
                        r_dat_out <= 1'b0;      // start bit
                        r_dat_oe  <= 1'b1;
                        r_state   <= TX_START;
                    end else if (enable_stp_wrapper && !enable_pts_wrapper) begin
                        r_mode  <= waiting_response;
                        r_crc   <= CRC_INIT;
                        r_state <= RX_WAIT;
                    end
                end
                // Output is registered one step ahead: each state loads the
                // bit that appears on the pad during the following cycle.
                TX_START: begin
                    r_dat_out <= r_shift[31];
                    r_crc     <= w_crc_tx_next;
                    r_shift   <= {r_shift[30:0], 1'b0};
                    r_cnt     <= '0;
                    r_state   <= TX_DATA;
                end
                TX_DATA: begin
                    if (r_cnt == 6'd31) begin
                        // all 32 data bits are already folded into r_crc
                        r_dat_out <= r_crc[15];
                        r_crc     <= {r_crc[14:0], 1'b0};
                        r_cnt     <= '0;
                        r_state   <= TX_CRC;
                    end else begin
                        r_dat_out <= r_shift[31];
                        r_crc     <= w_crc_tx_next;
                        r_shift   <= {r_shift[30:0], 1'b0};
                        r_cnt     <= r_cnt + 6'd1;
                    end
                end
                TX_CRC: begin
                    if (r_cnt == 6'd15) begin
                        r_dat_out <= 1'b1;      // end bit
                        r_state   <= TX_END;
                    end else begin
                        r_dat_out <= r_crc[15];
                        r_crc     <= {r_crc[14:0], 1'b0};
                        r_cnt     <= r_cnt + 6'd1;
                    end
                end
                TX_END: begin
                    r_dat_out <= 1'b1;
                    r_dat_oe  <= 1'b0;
                    r_tx_done <= 1'b1;
                    r_state   <= TX_DONE;
                end
                TX_DONE: r_state <= IDLE;
                RX_WAIT: begin
                    if (!dat_in) begin
                        r_cnt   <= '0;
                        r_crc   <= CRC_INIT;
                        r_state <= r_mode ? TOK_STAT : RX_DATA;
                    end
                end
                RX_DATA: begin
                    r_shift <= {r_shift[30:0], dat_in};
                    r_crc   <= w_crc_rx_next;
                    if (r_cnt == 6'd31) begin
                        r_cnt   <= '0;
                        r_state <= RX_CRC;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                RX_CRC: begin
                    r_crc_rx <= {r_crc_rx[14:0], dat_in};
                    if (r_cnt == 6'd15) begin
                        r_cnt   <= '0;
                        r_state <= RX_END;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                RX_END: begin
                    r_data_read <= r_shift;
                    r_crc_error <= (r_crc_rx != r_crc) || !dat_in;
                    r_rx_done   <= 1'b1;
                    r_state     <= RX_DONE;
                end
                TOK_STAT: begin
                    r_crc_status <= {r_crc_status[1:0], dat_in};
                    if (r_cnt == 6'd2) begin
                        r_cnt   <= '0;
                        r_state <= TOK_END;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                TOK_END: begin
                    r_end_ok <= dat_in;
                    r_state  <= BUSY;
                end
                BUSY: begin
                    // card holds DAT0 low while programming
                    if (dat_in) begin
                        r_crc_error <= (r_crc_status != 3'b010) || !r_end_ok;
                        r_rx_done   <= 1'b1;
                        r_state     <= RX_DONE;
                    end
                end
                RX_DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dat_out               = r_dat_out;
    assign dat_oe                = r_dat_oe;
    assign transmission_complete = r_tx_done;
    assign reception_complete    = r_rx_done;
    assign dataRead              = r_data_read;
    assign crc_error             = r_crc_error;
    assign crc_status            = r_crc_status;

endmodule

// File: tb/tb_sd_dat_serdes.sv
// Testbench for sd_dat_serdes. The bench holds a frame-level model: each
// transmit pushes the expected per-cycle pad values into a queue, and each
// receive updates the expected result registers at the cycle they should
// change. One compare process checks all outputs every cycle.
module tb_sd_dat_serdes;

    logic        sd_clock = 1'b0;
    logic        reset = 1'b1;
    logic        reset_wrapper = 1'b0;
    logic        load_send = 1'b0;
    logic        enable_pts_wrapper = 1'b0;
    logic        enable_stp_wrapper = 1'b0;
    logic        waiting_response = 1'b0;
    logic [31:0] dataPARALLEL = '0;
    logic        dat_in = 1'b1;
    logic        dat_out;
    logic        dat_oe;
    logic        transmission_complete;
    logic        reception_complete;
    logic [31:0] dataRead;
    logic        crc_error;
    logic [2:0]  crc_status;

    sd_dat_serdes dut (
        .sd_clock(sd_clock), .reset(reset), .reset_wrapper(reset_wrapper),
        .load_send(load_send), .enable_pts_wrapper(enable_pts_wrapper),
        .enable_stp_wrapper(enable_stp_wrapper), .waiting_response(waiting_response),
        .dataPARALLEL(dataPARALLEL), .dat_in(dat_in), .dat_out(dat_out), .dat_oe(dat_oe),
        .transmission_complete(transmission_complete), .reception_complete(reception_complete),
        .dataRead(dataRead), .crc_error(crc_error), .crc_status(crc_status)
    );

    always #5 sd_clock = ~sd_clock;

    typedef struct packed {
        logic oe;
        logic out;
        logic tc;
    } pad_t;

    pad_t        exp_q[$];
    logic        chk_on = 1'b0;
    logic        m_rc = 1'b0;
    logic [31:0] m_dr = '0;
    logic        m_ce = 1'b0;
    logic [2:0]  m_cs = '0;
    int          oe_cycles = 0;
    int          tc_pulses = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // CRC16-CCITT (init 0) over the low n bits of d, MSB first.
    function automatic logic [15:0] crc16(input logic [71:0] d, input int n);
        logic [15:0] c;
        c = 16'h0000;
        for (int i = n - 1; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = (c << 1) ^ 16'h1021;
            else              c = c << 1;
        end
        return c;
    endfunction

    always @(negedge sd_clock) begin
        pad_t e;
        if (chk_on) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : pad_t'(3'b010);
            chk("dat_oe", {31'd0, dat_oe}, {31'd0, e.oe});
            chk("dat_out", {31'd0, dat_out}, {31'd0, e.out});
            chk("transmission_complete", {31'd0, transmission_complete}, {31'd0, e.tc});
            chk("reception_complete", {31'd0, reception_complete}, {31'd0, m_rc});
            chk("dataRead", dataRead, m_dr);
            chk("crc_error", {31'd0, crc_error}, {31'd0, m_ce});
            chk("crc_status", {29'd0, crc_status}, {29'd0, m_cs});
            if (dat_oe === 1'b1) oe_cycles++;
            if (transmission_complete === 1'b1) tc_pulses++;
        end
    end

    task automatic tick();
        @(posedge sd_clock);
        #1;
    endtask

    // Push the whole expected frame: 50 driven bits then the done cycle.
    task automatic push_frame(input logic [31:0] w);
        logic [15:0] c;
        c = crc16({40'd0, w}, 32);
        exp_q.push_back('{1'b1, 1'b0, 1'b0});
        for (int i = 31; i >= 0; i--) exp_q.push_back('{1'b1, w[i], 1'b0});
        for (int i = 15; i >= 0; i--) exp_q.push_back('{1'b1, c[i], 1'b0});
        exp_q.push_back('{1'b1, 1'b1, 1'b0});
        exp_q.push_back('{1'b0, 1'b1, 1'b1});
    endtask

    task automatic tx(input logic [31:0] w, input logic stp_too);
        dataPARALLEL = w;
        load_send = 1'b1;
        enable_pts_wrapper = 1'b1;
        enable_stp_wrapper = stp_too;
        tick();
        push_frame(w);
        load_send = 1'b0;
        enable_pts_wrapper = 1'b0;   // dropping the enable must not abort
        enable_stp_wrapper = 1'b0;
        dataPARALLEL = ~w;
        repeat (51) tick();
    endtask

    task automatic rx_data(input logic [31:0] w, input logic flip);
        logic [15:0] c;
        c = crc16({40'd0, w}, 32);
        if (flip) c[3] = ~c[3];
        enable_stp_wrapper = 1'b1;
        waiting_response = 1'b0;
        tick();
        enable_stp_wrapper = 1'b0;
        dat_in = 1'b1;
        tick();
        dat_in = 1'b0;
        tick();
        for (int i = 31; i >= 0; i--) begin dat_in = w[i]; tick(); end
        for (int i = 15; i >= 0; i--) begin dat_in = c[i]; tick(); end
        dat_in = 1'b1;
        tick();
        m_dr = w;
        m_ce = flip;
        m_rc = 1'b1;
        tick();
        m_rc = 1'b0;
    endtask

    task automatic rx_token(input logic [2:0] s, input int busy);
        enable_stp_wrapper = 1'b1;
        waiting_response = 1'b1;
        tick();
        enable_stp_wrapper = 1'b0;
        waiting_response = 1'b0;
        dat_in = 1'b0;
        tick();
        for (int i = 2; i >= 0; i--) begin
            dat_in = s[i];
            tick();
            m_cs = {m_cs[1:0], s[i]};
        end
        dat_in = 1'b1;
        tick();
        dat_in = 1'b0;
        repeat (busy) tick();
        dat_in = 1'b1;
        tick();
        m_ce = (s != 3'b010);
        m_rc = 1'b1;
        tick();
        m_rc = 1'b0;
    endtask

    initial begin
        tick();
        chk_on = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // pin the model against known CRC-16/XMODEM values
        chk("model_crc_123456789", {16'd0, crc16(72'h313233343536373839, 72)}, 32'h0000_31C3);
        chk("model_crc_zero", {16'd0, crc16(72'd0, 32)}, 32'h0);

        oe_cycles = 0;
        tc_pulses = 0;
        tx(32'h0000_0000, 1'b0);
        chk("oe_cycles_zero_word", oe_cycles, 50);
        chk("tc_pulses_zero_word", tc_pulses, 1);

        tx(32'hA5A5_F00F, 1'b0);

        rx_data(32'h1234_5678, 1'b0);
        chk("dataRead_literal", dataRead, 32'h1234_5678);
        chk("crc_error_good", {31'd0, crc_error}, 32'd0);

        rx_data(32'h1234_5678, 1'b1);
        chk("crc_error_flipped", {31'd0, crc_error}, 32'd1);

        rx_token(3'b010, 20);
        chk("crc_status_literal", {29'd0, crc_status}, 32'd2);
        chk("token_ok_error", {31'd0, crc_error}, 32'd0);

        rx_token(3'b101, 3);
        chk("token_bad_error", {31'd0, crc_error}, 32'd1);

        // abort during data bit 20 of the frame
        tc_pulses = 0;
        dataPARALLEL = 32'hC3C3_3C3C;
        load_send = 1'b1;
        enable_pts_wrapper = 1'b1;
        tick();
        push_frame(32'hC3C3_3C3C);
        load_send = 1'b0;
        enable_pts_wrapper = 1'b0;
        repeat (19) tick();
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        reset_wrapper = 1'b1;
        tick();
        reset_wrapper = 1'b0;
        repeat (3) tick();
        chk("abort_no_tc", tc_pulses, 0);
        chk("abort_dataRead_kept", dataRead, 32'h1234_5678);

        // load_send wins over receive enable; back-to-back receive after
        oe_cycles = 0;
        tx(32'hDEAD_BEEF, 1'b1);
        chk("oe_cycles_both_en", oe_cycles, 50);
        rx_data(32'h8000_0001, 1'b0);
        repeat (3) tick();

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
        $fatal(1, "timeout");
    end

endmodule
